// File: rtl/wb_regfile_if.sv
// rtl/wb_regfile_if.sv - MEM/WB write-back, ID read-port and retire-trace signal bundle
interface wb_regfile_if #(
    parameter int DATA_W = 32,
    parameter int IA_W   = 8
);
    logic              wb_reg_write;
    logic [4:0]        wb_write_register;
    logic [1:0]        wb_memto_reg;
    logic [DATA_W-1:0] wb_alu_out;
    logic [DATA_W-1:0] wb_read_data;
    logic [DATA_W-1:0] wb_pc4;
    logic [IA_W-1:0]   wb_inst_addr;
    logic [DATA_W-1:0] wb_write_data;
    logic [4:0]        id_rs_addr;
    logic [4:0]        id_rt_addr;
    logic [DATA_W-1:0] id_rs_data;
    logic [DATA_W-1:0] id_rt_data;
    logic [31:0]       commit_count;
    logic              trace_ready;
    logic              trace_valid;
    logic [IA_W-1:0]   trace_inst_addr;
    logic [4:0]        trace_reg;
    logic [DATA_W-1:0] trace_data;
    logic              trace_overflow;

    modport master (
        output wb_reg_write, wb_write_register, wb_memto_reg, wb_alu_out, wb_read_data,
               wb_pc4, wb_inst_addr, id_rs_addr, id_rt_addr, trace_ready,
        input  wb_write_data, id_rs_data, id_rt_data, commit_count, trace_valid,
               trace_inst_addr, trace_reg, trace_data, trace_overflow
    );

    modport slave (
        input  wb_reg_write, wb_write_register, wb_memto_reg, wb_alu_out, wb_read_data,
               wb_pc4, wb_inst_addr, id_rs_addr, id_rt_addr, trace_ready,
        output wb_write_data, id_rs_data, id_rt_data, commit_count, trace_valid,
               trace_inst_addr, trace_reg, trace_data, trace_overflow
    );
endinterface

// File: rtl/wb_regfile.sv
// rtl/wb_regfile.sv - write-back select, 32x32 GPR file with bypassed reads, commit counter
// Optional retire-trace FIFO enabled by defining RETIRE_TRACE_EN.
module wb_regfile #(
    parameter int DATA_W      = 32,
    parameter int IA_W        = 8,
    parameter int TRACE_DEPTH = 4
) (
    input  logic         clk,
    input  logic         reset,
    wb_regfile_if.slave  bus
);
    logic [DATA_W-1:0] wb_data;
    logic              commit;
    logic [DATA_W-1:0] gpr_q [32];
    logic [DATA_W-1:0] gpr_d [32];
    logic [31:0]       commit_count_q;
    logic [31:0]       commit_count_d;

    always_comb begin
        wb_data = bus.wb_alu_out;
        case (bus.wb_memto_reg)
            2'b01:   wb_data = bus.wb_read_data;
            2'b10:   wb_data = bus.wb_pc4;
            default: wb_data = bus.wb_alu_out;
        endcase
    end

    assign commit            = bus.wb_reg_write && (bus.wb_write_register != 5'd0);
    assign bus.wb_write_data = wb_data;
    assign bus.commit_count  = commit_count_q;

    always_comb begin
        gpr_d          = gpr_q;
        commit_count_d = commit_count_q;
        if (commit) begin
            gpr_d[bus.wb_write_register] = wb_data;
            commit_count_d               = commit_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gpr_q          <= '{default: '0};
            commit_count_q <= '0;
        end else begin
            gpr_q          <= gpr_d;
            commit_count_q <= commit_count_d;
        end
    end

    // Bypass gives the ID stage the value being written this cycle (write-before-read).
    always_comb begin
        bus.id_rs_data = gpr_q[bus.id_rs_addr];
        if (bus.id_rs_addr == 5'd0)
            bus.id_rs_data = '0;
        else if (commit && (bus.id_rs_addr == bus.wb_write_register))
            bus.id_rs_data = wb_data;
    end

    always_comb begin
        bus.id_rt_data = gpr_q[bus.id_rt_addr];
        if (bus.id_rt_addr == 5'd0)
            bus.id_rt_data = '0;
        else if (commit && (bus.id_rt_addr == bus.wb_write_register))
            bus.id_rt_data = wb_data;
    end

`ifdef RETIRE_TRACE_EN
    localparam int PTR_W = (TRACE_DEPTH > 1) ? $clog2(TRACE_DEPTH) : 1;

    typedef struct packed {
        logic [IA_W-1:0]   tag;
        logic [4:0]        rd;
        logic [DATA_W-1:0] data;
    } trace_t;

    trace_t           fifo_q [TRACE_DEPTH];
    trace_t           fifo_d [TRACE_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             overflow_q, overflow_d;
    logic             full, empty, push, pop;

    assign empty = (count_q == '0);
    assign full  = (count_q == (PTR_W+1)'(TRACE_DEPTH));
    assign pop   = !empty && bus.trace_ready;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign push  = commit && (!full || pop);

    always_comb begin
        fifo_d     = fifo_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q || (commit && full && !pop);
        if (push) begin
            fifo_d[wr_ptr_q] = '{tag: bus.wb_inst_addr, rd: bus.wb_write_register, data: wb_data};
            wr_ptr_d         = wr_ptr_q + PTR_W'(1);
        end
        if (pop)
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        if (push && !pop)
            count_d = count_q + (PTR_W+1)'(1);
        else if (pop && !push)
            count_d = count_q - (PTR_W+1)'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fifo_q     <= '{default: '0};
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            fifo_q     <= fifo_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Head fields read as zero while empty so stale entries never leak out.
    assign bus.trace_valid     = !empty;
    assign bus.trace_inst_addr = empty ? '0 : fifo_q[rd_ptr_q].tag;
    assign bus.trace_reg       = empty ? '0 : fifo_q[rd_ptr_q].rd;
    assign bus.trace_data      = empty ? '0 : fifo_q[rd_ptr_q].data;
    assign bus.trace_overflow  = overflow_q;
`else
    logic unused_trace;

    assign unused_trace        = ^{bus.trace_ready, bus.wb_inst_addr, TRACE_DEPTH[0]};
    assign bus.trace_valid     = 1'b0;
    assign bus.trace_inst_addr = '0;
    assign bus.trace_reg       = '0;
    assign bus.trace_data      = '0;
    assign bus.trace_overflow  = 1'b0;
`endif
endmodule
